instr_fetcher: RTL and testbench
================================

INSTR_FETCHER -- requirements
Module: instr_fetcher

Interface
REQ-001 SHALL have parameter PC_RESET, default 64'h8000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk  in  1  the single clock; all state SHALL update on its rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port ireq_valid  out  1  instruction-bus request valid.
REQ-005 SHALL have port ireq_addr  out  64 (word_t)  fetch address.
REQ-006 SHALL have port iresp_addr_ok  in  1  bus accepted the address this cycle.
REQ-007 SHALL have port iresp_data_ok  in  1  bus returns data this cycle.
REQ-008 SHALL have port iresp_data  in  32 (u32)  instruction returned by the bus.
REQ-009 SHALL have port stall  in  1  downstream fetch stage cannot accept.
REQ-010 SHALL have port redirect_valid  in  1  branch/jump/exception redirect.
REQ-011 SHALL have port redirect_pc  in  64  redirect target.
REQ-012 SHALL have port out_valid  out  1  out_pc/out_instr hold a valid instruction.
REQ-013 SHALL have port out_pc  out  64  PC of the presented instruction.
REQ-014 SHALL have port out_instr  out  32  raw instruction, feeding the fetch stage pc/raw_instr inputs.

Function
REQ-015 SHALL implement a three-state FSM: REQ (ireq_valid=1), WAIT (address accepted, awaiting data), HOLD (instruction held while stall=1).
REQ-016 In REQ, ireq_addr SHALL stay constant until iresp_addr_ok; on iresp_addr_ok the FSM SHALL go to WAIT, or directly consume data if iresp_data_ok is also high the same cycle.
REQ-017 In WAIT, on iresp_data_ok with stall=0, the block SHALL assert out_valid combinationally that cycle with out_pc=pc, out_instr=iresp_data, set pc<=pc+4, and return to REQ.
REQ-018 On iresp_data_ok with stall=1, the block SHALL capture the instruction, go to HOLD, and keep out_valid=1 with stable out_pc/out_instr until a cycle with stall=0, then set pc<=pc+4 and go to REQ.
REQ-019 The best-case throughput SHALL be one instruction per two cycles with a 1-cycle bus; no request SHALL be issued in WAIT or HOLD (one outstanding request maximum).
REQ-020 redirect_valid SHALL take priority over stall and over returned data.
REQ-021 Redirect in HOLD, or in REQ before addr_ok: the held instruction or pending request SHALL be dropped (in REQ, ireq_addr SHALL switch to the new pc the next cycle; a request not yet accepted may change), out_valid=0, pc<=redirect_pc, state REQ.
REQ-022 Redirect in WAIT, or in the same cycle as addr_ok: a discard flag SHALL be set, pc<=redirect_pc; the returning data SHALL be dropped (out_valid=0), and the discard flag SHALL be cleared.
REQ-023 Redirect in the same cycle as iresp_data_ok SHALL drop that data, with out_valid=0.
REQ-024 Multiple redirects before the outstanding data returns SHALL be resolved so that the last one wins.
REQ-025 redirect_pc[1:0] SHALL be ignored (forced to 0); pc+4 SHALL wrap modulo 2^64.
REQ-026 out_valid SHALL never be asserted for data flagged as discarded.

Reset
REQ-027 Reset SHALL set pc=PC_RESET, state=REQ, discard=0, out_valid=0, out_pc=0, out_instr=0, immediately and asynchronously.
REQ-028 ireq_valid SHALL be 0 while reset is high and SHALL be 1 with ireq_addr=PC_RESET in the first cycle after reset deasserts.
REQ-029 Reset mid-transaction SHALL abandon the outstanding request; a late iresp_data_ok after reset SHALL be ignored unless in WAIT.

Structure
REQ-030 The ibus_req_t/ibus_resp_t structs and the PC_RESET constant SHALL live in the shared common package; the FSM state enum SHALL live in the pipes package.
REQ-031 The block SHALL be a single module with no sub-modules.

Verification
REQ-032 The bench SHALL cover: reset release, bus addr_ok+data_ok at latency 1, no stall -> requests at 8000_0000, 8000_0004, 8000_0008; out_valid every 2nd cycle with matching out_pc.
REQ-033 The bench SHALL cover: data 32'h0000_0013 returns while stall=1 for 3 cycles -> out_valid held 4 cycles, out_instr stable, next request at pc+4 only after stall drops.
REQ-034 The bench SHALL cover: redirect_valid to 8000_0100 in WAIT, data 32'hDEAD_BEEF returns 2 cycles later -> out_valid stays 0, next ireq_addr=8000_0100.
REQ-035 The bench SHALL cover: redirect to 8000_0200 coincident with iresp_data_ok -> data dropped, next request at 8000_0200.
REQ-036 The bench SHALL cover: redirect_pc=8000_0303 -> request issued at 8000_0300; two redirects (0x400 then 0x500) during WAIT -> request at 8000_0500.
REQ-037 The bench SHALL cover: reset asserted in WAIT, then released -> no out_valid, request at 8000_0000.

Source files
------------

// File: rtl/common_pkg.sv
// Shared types and constants for the core: machine word, bus bundles, reset PC.
// Imported by every pipeline block that talks to the instruction bus.
package common_pkg;

  typedef logic [63:0] word_t;
  typedef logic [31:0] u32;

  localparam word_t PC_RESET = 64'h8000_0000;

  typedef struct packed {
    logic  valid;
    word_t addr;
  } ibus_req_t;

  typedef struct packed {
    logic addrOk;
    logic dataOk;
    u32   data;
  } ibus_resp_t;

endpackage

// File: rtl/pipes_pkg.sv
// Pipeline-local types shared between front-end stages.
// Holds the instruction fetcher FSM state encoding.
package pipes_pkg;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD
  } fetch_state_t;

endpackage

// File: rtl/instr_fetcher.sv
// Instruction fetcher: one outstanding bus request, stall hold, redirect drop.
// Ports: clk/reset (async, active-high); ireq_* request out; iresp_* bus
// response in; stall/redirect_* from downstream; out_* instruction to fetch.
module instr_fetcher
  import common_pkg::*;
  import pipes_pkg::*;
#(
  parameter word_t PC_RESET = common_pkg::PC_RESET
) (
  input  logic  clk,
  input  logic  reset,
  output logic  ireq_valid,
  output word_t ireq_addr,
  input  logic  iresp_addr_ok,
  input  logic  iresp_data_ok,
  input  u32    iresp_data,
  input  logic  stall,
  input  logic  redirect_valid,
  input  word_t redirect_pc,
  output logic  out_valid,
  output word_t out_pc,
  output u32    out_instr
);

  fetch_state_t state, nextState;
  word_t        pc, pcNext;
  logic         discard, discardNext;
  u32           heldInstr, heldNext;

  ibus_req_t    req;
  ibus_resp_t   resp;
  word_t        tgt;
  logic         take;
  logic         holdShow;
  logic         valid;

  assign resp = {iresp_addr_ok, iresp_data_ok, iresp_data};
  assign tgt  = redirect_pc & ~64'd3;

  assign req        = {!reset && state == S_REQ, pc};
  assign ireq_valid = req.valid;
  assign ireq_addr  = req.addr;

  always_comb begin
    nextState   = state;
    pcNext      = pc;
    discardNext = discard;
    heldNext    = heldInstr;
    take        = 1'b0;
    holdShow    = 1'b0;
    unique case (state)
      S_REQ: begin
        if (redirect_valid) begin
          pcNext = tgt;
          // accepted but data still in flight: drop it when it lands
          if (resp.addrOk && !resp.dataOk) begin
            nextState   = S_WAIT;
            discardNext = 1'b1;
          end
        end else if (resp.addrOk) begin
          if (resp.dataOk) take = 1'b1;
          else nextState = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pcNext = tgt;
          if (resp.dataOk) begin
            nextState   = S_REQ;
            discardNext = 1'b0;
          end else begin
            discardNext = 1'b1;
          end
        end else if (resp.dataOk) begin
          if (discard) begin
            nextState   = S_REQ;
            discardNext = 1'b0;
          end else begin
            take = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pcNext    = tgt;
          nextState = S_REQ;
        end else begin
          holdShow = 1'b1;
          if (!stall) begin
            pcNext    = pc + 64'd4;
            nextState = S_REQ;
          end
        end
      end
      default: nextState = S_REQ;
    endcase
    if (take) begin
      if (stall) begin
        heldNext  = resp.data;
        nextState = S_HOLD;
      end else begin
        pcNext    = pc + 64'd4;
        nextState = S_REQ;
      end
    end
  end

  assign valid     = !reset && (take || holdShow);
  assign out_valid = valid;
  assign out_pc    = valid ? pc : '0;
  assign out_instr = !valid ? '0
                   : (state == S_HOLD) ? heldInstr
                   : resp.data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_REQ;
      pc        <= PC_RESET;
      discard   <= 1'b0;
      heldInstr <= '0;
    end else begin
      state     <= nextState;
      pc        <= pcNext;
      discard   <= discardNext;
      heldInstr <= heldNext;
    end
  end

endmodule

// File: tb/tb_instr_fetcher.sv
// Bench for instr_fetcher: directed scenarios plus a randomized bus/stall/
// redirect run checked against a transaction-level model.
module tb_instr_fetcher;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_addr_ok = 1'b0;
  logic        iresp_data_ok = 1'b0;
  logic [31:0] iresp_data = '0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_instr;

  int passes = 0;
  int checks = 0;
  logic [63:0] expPc;

  localparam logic [63:0] RST_PC = 64'h8000_0000;

  instr_fetcher dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_addr_ok(iresp_addr_ok), .iresp_data_ok(iresp_data_ok),
    .iresp_data(iresp_data), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    iresp_addr_ok = 0; iresp_data_ok = 0; stall = 0;
    redirect_valid = 0; iresp_data = $urandom;
  endtask

  task automatic drive(input logic a, input logic d, input logic [31:0] dat,
                       input logic s, input logic r, input logic [63:0] rp);
    iresp_addr_ok = a; iresp_data_ok = d; iresp_data = dat;
    stall = s; redirect_valid = r; redirect_pc = rp;
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ireq_valid !== 1'b0) $display("FAIL rst_req got %0b want 0", ireq_valid); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL rst_valid got %0b want 0", out_valid); else passes++;
    checks++; if (out_pc !== 64'd0) $display("FAIL rst_pc got %h want 0", out_pc); else passes++;
    checks++; if (out_instr !== 32'd0) $display("FAIL rst_instr got %h want 0", out_instr); else passes++;
    reset = 1'b0;
    #1;
    expPc = RST_PC;
    checks++; if (ireq_valid !== 1'b1) $display("FAIL rel_req got %0b want 1", ireq_valid); else passes++;
    checks++; if (ireq_addr !== expPc) $display("FAIL rel_addr got %h want %h", ireq_addr, expPc); else passes++;
    tick();
  endtask

  task automatic test_sequential();
    logic [31:0] d;
    for (int i = 0; i < 3; i++) begin
      checks++; if (ireq_valid !== 1'b1 || ireq_addr !== expPc)
        $display("FAIL seq_addr got %0b/%h want 1/%h", ireq_valid, ireq_addr, expPc); else passes++;
      drive(1, 0, 0, 0, 0, 0);
      checks++; if (out_valid !== 1'b0) $display("FAIL seq_gap got %0b want 0", out_valid); else passes++;
      tick();
      checks++; if (ireq_valid !== 1'b0) $display("FAIL seq_noreq got %0b want 0", ireq_valid); else passes++;
      d = $urandom;
      drive(0, 1, d, 0, 0, 0);
      checks++; if (out_valid !== 1'b1 || out_pc !== expPc || out_instr !== d)
        $display("FAIL seq_out got %0b/%h/%h want 1/%h/%h", out_valid, out_pc, out_instr, expPc, d); else passes++;
      tick();
      expPc += 64'd4;
    end
  endtask

  task automatic test_stall();
    drive(1, 0, 0, 0, 0, 0);
    tick();
    drive(0, 1, 32'h13, 1, 0, 0);
    checks++; if (out_valid !== 1'b1 || out_pc !== expPc || out_instr !== 32'h13)
      $display("FAIL stall_first got %0b/%h/%h want 1/%h/13", out_valid, out_pc, out_instr, expPc); else passes++;
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, $urandom, k < 2, 0, 0);
      checks++; if (out_valid !== 1'b1 || out_pc !== expPc || out_instr !== 32'h13)
        $display("FAIL stall_hold%0d got %0b/%h/%h want 1/%h/13", k, out_valid, out_pc, out_instr, expPc); else passes++;
      checks++; if (ireq_valid !== 1'b0) $display("FAIL stall_noreq%0d got %0b want 0", k, ireq_valid); else passes++;
      tick();
    end
    expPc += 64'd4;
    checks++; if (ireq_valid !== 1'b1 || ireq_addr !== expPc)
      $display("FAIL stall_next got %0b/%h want 1/%h", ireq_valid, ireq_addr, expPc); else passes++;
  endtask

  task automatic test_redirect_wait();
    drive(1, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 1, 64'h8000_0100);
    checks++; if (out_valid !== 1'b0) $display("FAIL rw_redir got %0b want 0", out_valid); else passes++;
    tick();
    checks++; if (ireq_valid !== 1'b0) $display("FAIL rw_noreq got %0b want 0", ireq_valid); else passes++;
    tick();
    drive(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
    checks++; if (out_valid !== 1'b0) $display("FAIL rw_drop got %0b want 0", out_valid); else passes++;
    tick();
    expPc = 64'h8000_0100;
    checks++; if (ireq_valid !== 1'b1 || ireq_addr !== expPc)
      $display("FAIL rw_next got %0b/%h want 1/%h", ireq_valid, ireq_addr, expPc); else passes++;
  endtask

  task automatic test_redirect_data();
    drive(1, 0, 0, 0, 0, 0);
    tick();
    drive(0, 1, $urandom, 0, 1, 64'h8000_0200);
    checks++; if (out_valid !== 1'b0) $display("FAIL rd_drop got %0b want 0", out_valid); else passes++;
    tick();
    expPc = 64'h8000_0200;
    checks++; if (ireq_valid !== 1'b1 || ireq_addr !== expPc)
      $display("FAIL rd_next got %0b/%h want 1/%h", ireq_valid, ireq_addr, expPc); else passes++;
  endtask

  task automatic test_redirect_multi();
    drive(0, 0, 0, 0, 1, 64'h8000_0303);
    tick();
    expPc = 64'h8000_0300;
    checks++; if (ireq_valid !== 1'b1 || ireq_addr !== expPc)
      $display("FAIL align got %0b/%h want 1/%h", ireq_valid, ireq_addr, expPc); else passes++;
    drive(1, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 1, 64'h8000_0400);
    tick();
    drive(0, 0, 0, 0, 1, 64'h8000_0500);
    tick();
    drive(0, 1, $urandom, 0, 0, 0);
    checks++; if (out_valid !== 1'b0) $display("FAIL multi_drop got %0b want 0", out_valid); else passes++;
    tick();
    expPc = 64'h8000_0500;
    checks++; if (ireq_valid !== 1'b1 || ireq_addr !== expPc)
      $display("FAIL multi_next got %0b/%h want 1/%h", ireq_valid, ireq_addr, expPc); else passes++;
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    drive(0, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE);
    tick();
    expPc = 64'hFFFF_FFFF_FFFF_FFFC;
    checks++; if (ireq_addr !== expPc) $display("FAIL wrap_addr got %h want %h", ireq_addr, expPc); else passes++;
    d = $urandom;
    drive(1, 1, d, 0, 0, 0);
    checks++; if (out_valid !== 1'b1 || out_pc !== expPc || out_instr !== d)
      $display("FAIL wrap_out got %0b/%h/%h want 1/%h/%h", out_valid, out_pc, out_instr, expPc, d); else passes++;
    tick();
    expPc = 64'd0;
    checks++; if (ireq_valid !== 1'b1 || ireq_addr !== expPc)
      $display("FAIL wrap_next got %0b/%h want 1/%h", ireq_valid, ireq_addr, expPc); else passes++;
  endtask

  task automatic test_reset_wait();
    drive(1, 0, 0, 0, 0, 0);
    tick();
    reset = 1'b1;
    #1;
    checks++; if (ireq_valid !== 1'b0 || out_valid !== 1'b0 || out_pc !== 64'd0)
      $display("FAIL rstw_mid got %0b/%0b/%h want 0/0/0", ireq_valid, out_valid, out_pc); else passes++;
    drive(0, 1, $urandom, 0, 0, 0);
    checks++; if (out_valid !== 1'b0) $display("FAIL rstw_data got %0b want 0", out_valid); else passes++;
    tick();
    reset = 1'b0;
    drive(0, 1, $urandom, 0, 0, 0);
    expPc = RST_PC;
    checks++; if (out_valid !== 1'b0) $display("FAIL rstw_late got %0b want 0", out_valid); else passes++;
    checks++; if (ireq_valid !== 1'b1 || ireq_addr !== expPc)
      $display("FAIL rstw_next got %0b/%h want 1/%h", ireq_valid, ireq_addr, expPc); else passes++;
    tick();
  endtask

  task automatic test_random();
    logic [63:0] modelPc, pendPc, holdPc, rpc, ePc;
    logic [31:0] holdIns, data;
    logic outst, stale, holding, expReq, redir, stl, aOk, dOk, expValid;
    int lat;
    modelPc = expPc; pendPc = '0; holdPc = '0; holdIns = '0;
    outst = 0; stale = 0; holding = 0; lat = 0;
    for (int c = 0; c < 400; c++) begin
      expReq = !outst && !holding;
      checks++; if (ireq_valid !== expReq)
        $display("FAIL rnd_req c%0d got %0b want %0b", c, ireq_valid, expReq); else passes++;
      if (expReq) begin
        checks++; if (ireq_addr !== modelPc)
          $display("FAIL rnd_addr c%0d got %h want %h", c, ireq_addr, modelPc); else passes++;
      end
      redir = ($urandom % 10) == 0;
      rpc = 64'h8000_0000 + 64'($urandom_range(0, 1023));
      stl = ($urandom % 3) == 0;
      data = $urandom;
      aOk = 0; dOk = 0;
      if (expReq) begin
        aOk = $urandom % 2;
        dOk = aOk && (($urandom % 4) == 0);
      end else if (outst) begin
        if (lat == 0) dOk = 1; else lat--;
      end
      drive(aOk, dOk, data, stl, redir, rpc);
      expValid = 0; ePc = '0;
      if (holding) begin
        expValid = !redir; ePc = holdPc;
      end else if (dOk) begin
        expValid = !redir && !(outst && stale);
        ePc = outst ? pendPc : modelPc;
      end
      checks++; if (out_valid !== expValid)
        $display("FAIL rnd_valid c%0d got %0b want %0b", c, out_valid, expValid); else passes++;
      if (expValid) begin
        checks++; if (out_pc !== ePc || out_instr !== (holding ? holdIns : data))
          $display("FAIL rnd_out c%0d got %h/%h want %h/%h", c, out_pc, out_instr, ePc,
                   holding ? holdIns : data); else passes++;
      end
      if (holding) begin
        if (redir) begin holding = 0; modelPc = rpc & ~64'd3; end
        else if (!stl) begin holding = 0; modelPc = holdPc + 64'd4; end
      end else if (outst) begin
        if (redir) begin stale = 1; modelPc = rpc & ~64'd3; end
        if (dOk) begin
          outst = 0;
          if (!stale) begin
            if (stl) begin holding = 1; holdPc = pendPc; holdIns = data; end
            else modelPc = pendPc + 64'd4;
          end
        end
      end else begin
        if (aOk && !dOk) begin
          outst = 1; stale = redir; pendPc = modelPc;
          lat = $urandom_range(0, 2);
        end else if (aOk && dOk && !redir) begin
          if (stl) begin holding = 1; holdPc = modelPc; holdIns = data; end
          else modelPc = modelPc + 64'd4;
        end
        if (redir) modelPc = rpc & ~64'd3;
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_redirect_data();
    test_redirect_multi();
    test_wrap();
    test_reset_wait();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
